// File: rtl/weighted_range_randomizer_if.sv
// Request/result handshake and table-config bus of weighted_range_randomizer.
interface weighted_range_randomizer_if #(
   parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
   parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
   parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 2,
   parameter int WEIGHT_WIDTH                      = 4
);
   localparam int INT_W     = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
   localparam int VAR_IDX_W = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
   localparam int CHOICE_W  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;

   logic                    in_cfg_we;
   logic [VAR_IDX_W-1:0]    in_cfg_var;
   logic [CHOICE_W-1:0]     in_cfg_choice;
   logic [INT_W-1:0]        in_cfg_start;
   logic [INT_W-1:0]        in_cfg_end;
   logic [WEIGHT_WIDTH-1:0] in_cfg_weight;
   logic                    in_req_valid;
   logic [VAR_IDX_W-1:0]    in_variable_index;
   logic                    out_req_ready;
   logic                    out_valid;
   logic [INT_W-1:0]        out_start;
   logic [INT_W-1:0]        out_end;
   logic                    out_equal;
   logic [CHOICE_W-1:0]     out_choice;
   logic [INT_W-1:0]        out_value;
   logic                    out_error;

   modport master (
      output in_cfg_we, in_cfg_var, in_cfg_choice, in_cfg_start, in_cfg_end, in_cfg_weight,
      output in_req_valid, in_variable_index,
      input  out_req_ready, out_valid, out_start, out_end, out_equal, out_choice, out_value, out_error
   );

   modport slave (
      input  in_cfg_we, in_cfg_var, in_cfg_choice, in_cfg_start, in_cfg_end, in_cfg_weight,
      input  in_req_valid, in_variable_index,
      output out_req_ready, out_valid, out_start, out_end, out_equal, out_choice, out_value, out_error
   );
endinterface

// File: rtl/weighted_range_randomizer.sv
// Weighted discrete-range randomizer: picks a range in proportion to its weight
// using an internal LFSR, then draws a uniform integer inside that range.
module weighted_range_randomizer #(
   parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
   parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
   parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 2,
   parameter int WEIGHT_WIDTH                      = 4,
   parameter int SEED_WIDTH                        = 16
) (
   input  logic                  in_clock,
   input  logic                  in_reset_n,
   input  logic                  in_enable,
   input  logic [SEED_WIDTH-1:0] in_seed,
   weighted_range_randomizer_if.slave bus
);
   localparam int INT_W     = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
   localparam int VAR_IDX_W = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
   localparam int CHOICE_W  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
   localparam int SUM_W     = WEIGHT_WIDTH + CHOICE_W;
   localparam int ENT_W     = VAR_IDX_W + CHOICE_W;
   localparam int ENTRIES   = 1 << ENT_W;

   function automatic logic [63:0] lfsr_taps(input int width);
      case (width)
         8:       return 64'h0000_0000_0000_00B8;
         12:      return 64'h0000_0000_0000_0829;
         16:      return 64'h0000_0000_0000_B400;
         20:      return 64'h0000_0000_0009_0000;
         24:      return 64'h0000_0000_00E1_0000;
         32:      return 64'h0000_0000_8020_0003;
         default: return 64'h0000_0000_0000_0003 << (width - 2);
      endcase
   endfunction

   function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [INT_W-1:0] s,
                                                          input logic [INT_W-1:0] e,
                                                          input logic [WEIGHT_WIDTH-1:0] w);
      if (e >= s) begin
         return w;
      end else begin
         return {WEIGHT_WIDTH{1'b0}};
      end
   endfunction

   localparam logic [63:0]           TAPS_ALL = lfsr_taps(SEED_WIDTH);
   localparam logic [SEED_WIDTH-1:0] TAPS     = TAPS_ALL[SEED_WIDTH-1:0];
   localparam logic [CHOICE_W-1:0]   CNT_LAST = {CHOICE_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SUM   = 3'd1,
      S_DRAW  = 3'd2,
      S_SCAN  = 3'd3,
      S_VALUE = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [SEED_WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [INT_W-1:0]        tbl_start_q [ENTRIES];
   logic [INT_W-1:0]        tbl_start_d [ENTRIES];
   logic [INT_W-1:0]        tbl_end_q [ENTRIES];
   logic [INT_W-1:0]        tbl_end_d [ENTRIES];
   logic [WEIGHT_WIDTH-1:0] tbl_weight_q [ENTRIES];
   logic [WEIGHT_WIDTH-1:0] tbl_weight_d [ENTRIES];
   logic [VAR_IDX_W-1:0]    var_q, var_d;
   logic [CHOICE_W-1:0]     cnt_q, cnt_d;
   logic [SUM_W-1:0]        total_q, total_d;
   logic [SUM_W-1:0]        r_q, r_d;
   logic [SUM_W-1:0]        cum_q, cum_d;
   logic                    found_q, found_d;
   logic [CHOICE_W-1:0]     sel_q, sel_d;
   logic                    valid_q, valid_d;
   logic                    ready_q, ready_d;
   logic [INT_W-1:0]        res_start_q, res_start_d;
   logic [INT_W-1:0]        res_end_q, res_end_d;
   logic                    res_equal_q, res_equal_d;
   logic [CHOICE_W-1:0]     res_choice_q, res_choice_d;
   logic [INT_W-1:0]        res_value_q, res_value_d;
   logic                    res_error_q, res_error_d;

   logic                    accept_s;
   logic                    cfg_write_s;
   logic [ENT_W-1:0]        cfg_idx_s;
   logic [ENT_W-1:0]        ent_idx_s;
   logic [ENT_W-1:0]        sel_idx_s;
   logic [WEIGHT_WIDTH-1:0] cur_eff_s;
   logic [SUM_W-1:0]        cum_next_s;
   logic [2*SUM_W-1:0]      draw_prod_s;
   logic [SUM_W-1:0]        r_s;
   logic [INT_W-1:0]        sel_start_s;
   logic [INT_W-1:0]        sel_end_s;
   logic [INT_W:0]          span_s;
   logic [2*INT_W-1:0]      val_prod_s;
   logic [INT_W-1:0]        sel_value_s;
   logic [SEED_WIDTH-1:0]   seed_load_s;

   assign accept_s    = in_enable && (state_q == S_IDLE) && bus.in_req_valid;
   assign cfg_write_s = bus.in_cfg_we && (state_q == S_IDLE) && !accept_s;
   assign cfg_idx_s   = {bus.in_cfg_var, bus.in_cfg_choice};
   assign ent_idx_s   = {var_q, cnt_q};
   assign sel_idx_s   = {var_q, sel_q};
   assign seed_load_s = (in_seed == {SEED_WIDTH{1'b0}}) ? {{(SEED_WIDTH-1){1'b0}}, 1'b1} : in_seed;
   assign lfsr_d      = in_enable ? {lfsr_q[SEED_WIDTH-2:0], ^(lfsr_q & TAPS)} : lfsr_q;

   assign cur_eff_s   = eff_weight(tbl_start_q[ent_idx_s], tbl_end_q[ent_idx_s], tbl_weight_q[ent_idx_s]);
   assign cum_next_s  = cum_q + SUM_W'(cur_eff_s);
   // r = (lfsr_low * total) >> SUM_W always lands in [0, total) for a non-zero total
   assign draw_prod_s = (2*SUM_W)'(lfsr_q[SUM_W-1:0]) * (2*SUM_W)'(total_q);
   assign r_s         = SUM_W'(draw_prod_s >> SUM_W);
   assign sel_start_s = tbl_start_q[sel_idx_s];
   assign sel_end_s   = tbl_end_q[sel_idx_s];
   assign span_s      = {1'b0, sel_end_s} - {1'b0, sel_start_s} + (INT_W+1)'(1);
   assign val_prod_s  = (2*INT_W)'(lfsr_q[SEED_WIDTH-1 -: INT_W]) * (2*INT_W)'(span_s);
   assign sel_value_s = sel_start_s + INT_W'(val_prod_s >> INT_W);

   always_ff @(posedge in_clock) begin
      if (!in_reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_enable) begin
         case (state_q)
            S_IDLE:  state_d = bus.in_req_valid ? S_SUM : S_IDLE;
            S_SUM:   state_d = (cnt_q == CNT_LAST) ? S_DRAW : S_SUM;
            S_DRAW:  state_d = S_SCAN;
            S_SCAN:  state_d = (cnt_q == CNT_LAST) ? S_VALUE : S_SCAN;
            S_VALUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      tbl_start_d  = tbl_start_q;
      tbl_end_d    = tbl_end_q;
      tbl_weight_d = tbl_weight_q;
      if (cfg_write_s) begin
         tbl_start_d[cfg_idx_s]  = bus.in_cfg_start;
         tbl_end_d[cfg_idx_s]    = bus.in_cfg_end;
         tbl_weight_d[cfg_idx_s] = bus.in_cfg_weight;
      end else begin
         tbl_start_d = tbl_start_q;
      end
   end

   always_comb begin
      var_d        = var_q;
      cnt_d        = cnt_q;
      total_d      = total_q;
      r_d          = r_q;
      cum_d        = cum_q;
      found_d      = found_q;
      sel_d        = sel_q;
      valid_d      = valid_q;
      ready_d      = ready_q;
      res_start_d  = res_start_q;
      res_end_d    = res_end_q;
      res_equal_d  = res_equal_q;
      res_choice_d = res_choice_q;
      res_value_d  = res_value_q;
      res_error_d  = res_error_q;
      if (in_enable) begin
         valid_d = 1'b0;
         ready_d = (state_d == S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  var_d   = bus.in_variable_index;
                  cnt_d   = {CHOICE_W{1'b0}};
                  total_d = {SUM_W{1'b0}};
               end else begin
                  var_d = var_q;
               end
            end
            S_SUM: begin
               total_d = cum_q + total_q - cum_q + SUM_W'(cur_eff_s);
               cnt_d   = cnt_q + CHOICE_W'(1);
            end
            S_DRAW: begin
               r_d     = r_s;
               cum_d   = {SUM_W{1'b0}};
               found_d = 1'b0;
               sel_d   = {CHOICE_W{1'b0}};
               cnt_d   = {CHOICE_W{1'b0}};
            end
            S_SCAN: begin
               cum_d = cum_next_s;
               cnt_d = cnt_q + CHOICE_W'(1);
               // first match wins; later choices with r < cum are ignored
               if (!found_q && (r_q < cum_next_s)) begin
                  found_d = 1'b1;
                  sel_d   = cnt_q;
               end else begin
                  found_d = found_q;
               end
            end
            S_VALUE: begin
               valid_d = 1'b1;
               if (total_q == {SUM_W{1'b0}}) begin
                  res_start_d  = {INT_W{1'b0}};
                  res_end_d    = {INT_W{1'b0}};
                  res_equal_d  = 1'b0;
                  res_choice_d = {CHOICE_W{1'b0}};
                  res_value_d  = {INT_W{1'b0}};
                  res_error_d  = 1'b1;
               end else begin
                  res_start_d  = sel_start_s;
                  res_end_d    = sel_end_s;
                  res_equal_d  = (sel_start_s == sel_end_s);
                  res_choice_d = sel_q;
                  res_value_d  = sel_value_s;
                  res_error_d  = 1'b0;
               end
            end
            default: begin
               var_d = var_q;
            end
         endcase
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset_n) begin
         lfsr_q       <= seed_load_s;
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_start_q[i]  <= {INT_W{1'b0}};
            tbl_end_q[i]    <= {INT_W{1'b0}};
            tbl_weight_q[i] <= {WEIGHT_WIDTH{1'b0}};
         end
         var_q        <= {VAR_IDX_W{1'b0}};
         cnt_q        <= {CHOICE_W{1'b0}};
         total_q      <= {SUM_W{1'b0}};
         r_q          <= {SUM_W{1'b0}};
         cum_q        <= {SUM_W{1'b0}};
         found_q      <= 1'b0;
         sel_q        <= {CHOICE_W{1'b0}};
         valid_q      <= 1'b0;
         ready_q      <= 1'b1;
         res_start_q  <= {INT_W{1'b0}};
         res_end_q    <= {INT_W{1'b0}};
         res_equal_q  <= 1'b0;
         res_choice_q <= {CHOICE_W{1'b0}};
         res_value_q  <= {INT_W{1'b0}};
         res_error_q  <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         tbl_start_q  <= tbl_start_d;
         tbl_end_q    <= tbl_end_d;
         tbl_weight_q <= tbl_weight_d;
         var_q        <= var_d;
         cnt_q        <= cnt_d;
         total_q      <= total_d;
         r_q          <= r_d;
         cum_q        <= cum_d;
         found_q      <= found_d;
         sel_q        <= sel_d;
         valid_q      <= valid_d;
         ready_q      <= ready_d;
         res_start_q  <= res_start_d;
         res_end_q    <= res_end_d;
         res_equal_q  <= res_equal_d;
         res_choice_q <= res_choice_d;
         res_value_q  <= res_value_d;
         res_error_q  <= res_error_d;
      end
   end

   assign bus.out_req_ready = ready_q;
   assign bus.out_valid     = valid_q;
   assign bus.out_start     = res_start_q;
   assign bus.out_end       = res_end_q;
   assign bus.out_equal     = res_equal_q;
   assign bus.out_choice    = res_choice_q;
   assign bus.out_value     = res_value_q;
   assign bus.out_error     = res_error_q;
endmodule

// File: tb/tb_weighted_range_randomizer.sv
// Scoreboard bench for weighted_range_randomizer: expectations are queued at
// request acceptance and checked by an independent monitor on out_valid.
module tb_weighted_range_randomizer;
   typedef struct packed {
      logic [7:0]  st;
      logic [7:0]  en_;
      logic        eq;
      logic [1:0]  ch;
      logic [7:0]  val;
      logic        err;
      logic [1:0]  vr;
      logic [31:0] due;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [15:0] seed = 16'd0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_valid_seen = 0;
   int          n_v0 = 0;
   int          n_c3 = 0;
   logic [15:0] m_lfsr;
   logic [7:0]  m_start [16];
   logic [7:0]  m_end [16];
   logic [3:0]  m_w [16];
   res_t        exp_q [$];
   res_t        mon_exp, mon_got, last_res, ref_res;

   always #5 clk = ~clk;

   weighted_range_randomizer_if #(
      .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE(8), .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(2),
      .MAX_BIT_WIDTH_OF_DISCRETE_CHOICES(2), .WEIGHT_WIDTH(4)
   ) bus ();

   weighted_range_randomizer #(
      .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE(8), .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(2),
      .MAX_BIT_WIDTH_OF_DISCRETE_CHOICES(2), .WEIGHT_WIDTH(4), .SEED_WIDTH(16)
   ) dut (
      .in_clock(clk), .in_reset_n(rst_n), .in_enable(en), .in_seed(seed), .bus(bus)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [27:0] flds(input res_t r);
      return {r.st, r.en_, r.eq, r.ch, r.val, r.err};
   endfunction

   function automatic res_t predict(input logic [1:0] v, input logic [15:0] l0);
      res_t p;
      int eff [4];
      int total, cum, r, ch, idx, span;
      logic [15:0] ld, lv;
      p = '0;
      p.vr = v;
      total = 0;
      for (int c = 0; c < 4; c++) begin
         idx = int'(v) * 4 + c;
         eff[c] = (m_end[idx] >= m_start[idx] && m_w[idx] != 4'd0) ? int'(m_w[idx]) : 0;
         total += eff[c];
      end
      ld = l0;
      for (int k = 0; k < 5; k++) ld = lfsr_next(ld);
      lv = l0;
      for (int k = 0; k < 10; k++) lv = lfsr_next(lv);
      if (total == 0) begin
         p.err = 1'b1;
         return p;
      end
      r = (int'(ld[5:0]) * total) >> 6;
      cum = 0;
      ch = -1;
      for (int c = 0; c < 4; c++) begin
         cum += eff[c];
         if (ch < 0 && r < cum) ch = c;
      end
      idx = int'(v) * 4 + ch;
      span = int'(m_end[idx]) - int'(m_start[idx]) + 1;
      p.st = m_start[idx];
      p.en_ = m_end[idx];
      p.eq = (m_start[idx] == m_end[idx]);
      p.ch = 2'(ch);
      p.val = 8'(int'(m_start[idx]) + ((int'(lv[15:8]) * span) >> 8));
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!rst_n) m_lfsr <= (seed == 16'd0) ? 16'd1 : seed;
      else if (en) m_lfsr <= lfsr_next(m_lfsr);
   end

   always @(negedge clk) begin
      if (rst_n && en && bus.out_valid) begin
         n_valid_seen++;
         mon_got = '0;
         mon_got.st = bus.out_start;
         mon_got.en_ = bus.out_end;
         mon_got.eq = bus.out_equal;
         mon_got.ch = bus.out_choice;
         mon_got.val = bus.out_value;
         mon_got.err = bus.out_error;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", 64'(flds(mon_got)), 64'(flds(mon_exp)));
            check("latency_cycle", 64'(cyc), 64'(mon_exp.due));
            if (mon_exp.vr == 2'd0) begin
               n_v0++;
               if (mon_got.ch == 2'd3) n_c3++;
            end
         end
         last_res = mon_got;
      end
   end

   task automatic do_reset(input logic [15:0] s);
      @(posedge clk); #1;
      rst_n = 1'b0;
      seed = s;
      en = 1'b1;
      bus.in_req_valid = 1'b0;
      bus.in_cfg_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_start[i] = 8'd0; m_end[i] = 8'd0; m_w[i] = 4'd0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_ready", 64'(bus.out_req_ready), 64'd1);
      check("reset_outputs", 64'({bus.out_valid, bus.out_start, bus.out_end, bus.out_equal,
                                  bus.out_choice, bus.out_value, bus.out_error}), 64'd0);
   endtask

   task automatic cfg_write(input logic [1:0] v, input logic [1:0] c, input logic [7:0] s,
                            input logic [7:0] e, input logic [3:0] w);
      bus.in_cfg_var = v; bus.in_cfg_choice = c;
      bus.in_cfg_start = s; bus.in_cfg_end = e; bus.in_cfg_weight = w;
      bus.in_cfg_we = 1'b1;
      @(posedge clk); #1;
      bus.in_cfg_we = 1'b0;
      m_start[int'(v) * 4 + int'(c)] = s;
      m_end[int'(v) * 4 + int'(c)] = e;
      m_w[int'(v) * 4 + int'(c)] = w;
   endtask

   task automatic do_req(input logic [1:0] v, input bit push, input int extra);
      res_t ex;
      bit ok;
      ok = 1'b0;
      bus.in_req_valid = 1'b1;
      bus.in_variable_index = v;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_req_ready && en) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         check("req_accept_timeout", 64'd0, 64'd1);
      end else if (push) begin
         ex = predict(v, m_lfsr);
         ex.due = 32'(cyc + 11 + extra);
         exp_q.push_back(ex);
      end
      @(posedge clk); #1;
      bus.in_req_valid = 1'b0;
      bus.in_cfg_we = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 80) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int vs_before;
      bus.in_cfg_we = 1'b0; bus.in_cfg_var = 2'd0; bus.in_cfg_choice = 2'd0;
      bus.in_cfg_start = 8'd0; bus.in_cfg_end = 8'd0; bus.in_cfg_weight = 4'd0;
      bus.in_req_valid = 1'b0; bus.in_variable_index = 2'd0;

      // Empty table, zero seed: error result, everything else zero
      do_reset(16'd0);
      do_req(2'd1, 1'b1, 0);
      wait_done();
      check("empty_table_error", 64'(flds(last_res)), 64'(28'h000_0001));

      // Single degenerate range [5,5]
      cfg_write(2'd2, 2'd0, 8'd5, 8'd5, 4'd3);
      do_req(2'd2, 1'b1, 0);
      wait_done();
      check("single_5_5", 64'(flds(last_res)), 64'({8'd5, 8'd5, 1'b1, 2'd0, 8'd5, 1'b0}));

      // Write while busy, then write coincident with accept: both dropped
      do_req(2'd2, 1'b1, 0);
      bus.in_cfg_var = 2'd2; bus.in_cfg_choice = 2'd0;
      bus.in_cfg_start = 8'd9; bus.in_cfg_end = 8'd9; bus.in_cfg_weight = 4'd3;
      bus.in_cfg_we = 1'b1;
      @(posedge clk); #1;
      bus.in_cfg_we = 1'b0;
      wait_done();
      bus.in_cfg_we = 1'b1;
      do_req(2'd2, 1'b1, 0);
      wait_done();
      do_req(2'd2, 1'b1, 0);
      wait_done();
      check("dropped_writes_readback", 64'(flds(last_res)), 64'({8'd5, 8'd5, 1'b1, 2'd0, 8'd5, 1'b0}));

      // Inverted range with heavy weight is ineligible
      cfg_write(2'd3, 2'd0, 8'd50, 8'd40, 4'd15);
      cfg_write(2'd3, 2'd2, 8'd7, 8'd9, 4'd1);
      for (int i = 0; i < 8; i++) do_req(2'd3, 1'b1, 0);
      wait_done();
      check("ineligible_skipped_choice", 64'(last_res.ch), 64'd2);
      check("ineligible_value_in_7_9", 64'(last_res.val >= 8'd7 && last_res.val <= 8'd9), 64'd1);

      // Weighted distribution: choice 3 should take about 3/4 of draws
      cfg_write(2'd0, 2'd1, 8'd10, 8'd20, 4'd1);
      cfg_write(2'd0, 2'd3, 8'd200, 8'd201, 4'd3);
      n_v0 = 0;
      n_c3 = 0;
      for (int i = 0; i < 4000; i++) do_req(2'd0, 1'b1, 0);
      wait_done();
      check("distribution_draw_count", 64'(n_v0), 64'd4000);
      check("choice3_fraction_0p72_0p78", 64'((n_c3 * 100 >= 72 * n_v0) && (n_c3 * 100 <= 78 * n_v0)), 64'd1);

      // Enable stall mid-SCAN matches an uninterrupted draw from the same seed
      do_reset(16'hACE1);
      cfg_write(2'd0, 2'd1, 8'd10, 8'd20, 4'd1);
      cfg_write(2'd0, 2'd3, 8'd200, 8'd201, 4'd3);
      do_req(2'd0, 1'b1, 0);
      wait_done();
      ref_res = last_res;
      do_reset(16'hACE1);
      cfg_write(2'd0, 2'd1, 8'd10, 8'd20, 4'd1);
      cfg_write(2'd0, 2'd3, 8'd200, 8'd201, 4'd3);
      do_req(2'd0, 1'b1, 5);
      repeat (6) @(posedge clk);
      #1 en = 1'b0;
      repeat (5) @(posedge clk);
      #1 en = 1'b1;
      wait_done();
      check("stall_equals_uninterrupted", 64'(flds(last_res)), 64'(flds(ref_res)));

      // Reset at T+4 aborts the draw
      cfg_write(2'd2, 2'd0, 8'd5, 8'd5, 4'd3);
      vs_before = n_valid_seen;
      do_req(2'd2, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_start[i] = 8'd0; m_end[i] = 8'd0; m_w[i] = 4'd0;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("abort_ready_next_cycle", 64'(bus.out_req_ready), 64'd1);
      check("abort_valid_low", 64'(bus.out_valid), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_valid", 64'(n_valid_seen), 64'(vs_before));
      do_req(2'd2, 1'b1, 0);
      wait_done();
      check("abort_table_cleared", 64'(last_res.err), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/weighted_range_randomizer.md
Name: weighted_range_randomizer

Overview:
- Parametrised successor to the discrete range randomizer in the MCMC constraint solver.
- Holds a per-variable table of discrete ranges (start, end, weight), loaded through a config write port.
- On each request it picks one range with probability proportional to its weight, using an internal LFSR.
- It then draws a uniform integer inside that range and returns start, end, equal flag, choice index and value under a valid/ready handshake.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 8, width INT_W of range bounds and drawn value.
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 2, variable index width; NV = 2^this variables.
- MAX_BIT_WIDTH_OF_DISCRETE_CHOICES, 2, choice index width; NC = 2^this ranges per variable.
- WEIGHT_WIDTH, 4, per-range weight width; SUM_W = WEIGHT_WIDTH + MAX_BIT_WIDTH_OF_DISCRETE_CHOICES.
- SEED_WIDTH, 16, LFSR width; must be >= SUM_W and >= INT_W.

Ports:
- in_clock  in  1  Single clock; all logic on the rising edge.
- in_reset_n  in  1  Reset, synchronous, active-low.
- in_enable  in  1  Global advance. When low, the FSM, LFSR and outputs hold.
- in_seed  in  SEED_WIDTH  LFSR load value, sampled during reset.
- in_cfg_we  in  1  Table write strobe.
- in_cfg_var  in  VAR_IDX_W  Variable index of the table entry to write.
- in_cfg_choice  in  CHOICE_W  Choice index of the table entry to write.
- in_cfg_start, in_cfg_end  in  INT_W each  Range bounds, inclusive.
- in_cfg_weight  in  WEIGHT_WIDTH  Range weight.
- in_req_valid  in  1  Draw request.
- in_variable_index  in  VAR_IDX_W  Variable to draw for; sampled on accept.
- out_req_ready  out  1  High only in IDLE.
- out_valid  out  1  One-cycle result strobe.
- out_start, out_end  out  INT_W each  Bounds of the chosen range.
- out_equal  out  1  out_start == out_end.
- out_choice  out  CHOICE_W  Chosen range index.
- out_value  out  INT_W  Uniform value in [out_start, out_end].
- out_error  out  1  No eligible range for the requested variable.

Behaviour:
- Reset (in_reset_n low at an edge):
  - All table entries cleared to 0.
  - LFSR loaded with in_seed; a zero seed loads 1 instead.
  - FSM goes to IDLE.
  - All result outputs go to 0; out_req_ready goes to 1.
  - Reset mid-draw aborts the draw with no out_valid.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1 at the default width; taps tabulated per SEED_WIDTH. Steps once per cycle while in_enable=1 and not in reset.
- Eligibility: a range is eligible iff end >= start AND weight != 0. Effective weight = weight if eligible, else 0.
- FSM (advances only when in_enable=1):
  - IDLE: accept when in_req_valid & out_req_ready (cycle T); latch the variable index; go to SUM.
  - SUM: NC cycles, choice 0..NC-1. Accumulate total weight (SUM_W bits, cannot overflow).
  - DRAW: 1 cycle. r = (lfsr[SUM_W-1:0] * total) >> SUM_W, so 0 <= r < total when total > 0.
  - SCAN: NC cycles. Running cumulative sum; select the first choice with r < cum. Later matches are ignored.
  - VALUE: 1 cycle. span = end - start + 1 (INT_W+1 bits). value = start + ((lfsr[SEED_WIDTH-1 -: INT_W] * span) >> INT_W).
  - Result registers load; go to IDLE.
- Latency: out_valid is high in cycle T + 2*NC + 3 only (11 cycles at defaults). out_req_ready rises in the same cycle, so back-to-back requests are allowed.
- Result outputs hold until the next result or reset.
- in_enable low mid-draw stretches latency by the number of low cycles. Results are otherwise identical to an uninterrupted run with the same LFSR state.
- total == 0: out_error=1; out_start = out_end = out_value = out_choice = 0; out_equal=0; same latency.
- Config writes:
  - Take effect at the next edge only while in IDLE and not accepting in that same cycle.
  - Writes while busy, or coincident with an accept, are dropped; the draw sees the old table.
- Full-width range (start=0, end=2^INT_W-1): span = 2^INT_W, no wrap; value = lfsr bits directly.

Test Plan:
- Reset with seed=0, then request variable 1 with an empty table -> out_valid at T+11; out_error=1; all other outputs 0; no hang.
- Var 2: choice 0 = [5,5] w=3, all others w=0 -> out_start=5, out_end=5, out_equal=1, out_value=5, out_choice=0, out_error=0.
- Var 0: choice 1 = [10,20] w=1, choice 3 = [200,201] w=3; 4000 draws -> choice 3 fraction 0.75±0.03; out_value always within the chosen bounds; out_equal=0.
- Entry with end<start and w=15 plus [7,9] w=1 -> choice with [7,9] always selected; out_value in {7,8,9}.
- Drop in_enable for 5 cycles mid-SCAN -> out_valid at T+16; results match an uninterrupted draw from the same seed.
- Config write during busy, and assert reset at T+4 of a draw -> the write is dropped (readback draw uses the old entry); reset aborts the draw, no out_valid, out_req_ready=1 the next cycle.
